// File: rtl/regfile_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// regfile_access_ctrl_pkg
//  Shared types and helpers for the register-array access controller.
//  - rfc_state_e : controller state (init walk / normal operation)
//  - next_rr_ptr : round-robin pointer advance past the granted requester
// ---------------------------------------------------------------------------
package regfile_access_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rfc_state_e;

    // Pointer moves to the requester just after the one granted, wrapping at n.
    function automatic int unsigned next_rr_ptr(input int unsigned g, input int unsigned n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// regfile_access_ctrl_if
//  Requester-side bus of the register-array access controller.
//  Per requester r: req_valid/req_ready handshake, req_write, req_idx[r],
//  req_wdata[r]; rsp_valid[r] one-cycle completion pulse. rsp_rdata is shared
//  and qualified by rsp_valid.
//  master : requester side (drives requests, sees grant and responses)
//  slave  : controller side
// ---------------------------------------------------------------------------
interface regfile_access_ctrl_if #(
    parameter int NREQ     = 2,
    parameter int IDXWIDTH = 3,
    parameter int WIDTH    = 32
);
    logic [NREQ-1:0]                req_valid;
    logic [NREQ-1:0]                req_ready;
    logic [NREQ-1:0]                req_write;
    logic [NREQ-1:0][IDXWIDTH-1:0]  req_idx;
    logic [NREQ-1:0][WIDTH-1:0]     req_wdata;
    logic [NREQ-1:0]                rsp_valid;
    logic [WIDTH-1:0]               rsp_rdata;

    modport master (
        output req_valid, req_write, req_idx, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_idx, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/regfile_access_ctrl_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//  Purely combinational round-robin pick: first set bit of valid scanning
//  upward from ptr (mod NREQ).
//  valid   in  NREQ  request vector
//  ptr     in  PW    highest-priority requester this cycle (< NREQ)
//  gnt     out NREQ  one-hot grant, zero when nothing is valid
//  gnt_idx out PW    binary index of the grant (0 when none)
//  gnt_any out 1     any grant issued
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx,
    output logic            gnt_any
);

    always_comb begin
        int k;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        k       = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NREQ) k = k - NREQ;
            if (!gnt_any && valid[k]) begin
                gnt_any = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = PW'(k);
            end
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_access_ctrl
//  Sequencer/arbiter in front of a single-port register array without reset.
//  After reset it writes INIT_VAL to every entry (NREGS cycles), then shares
//  the array port among NREQ requesters with round-robin arbitration.
//  Reads return one cycle after acceptance; writes are acked one cycle later.
//  Ports:
//   clk, rst_n       clock / async active-low reset
//   bus              requester bus (slave modport)
//   init_done        high from the first cycle after the init walk
//   rf_i, rf_d, rf_en array index, write data, write enable
//   rf_q             array read data, combinational from rf_i
// ---------------------------------------------------------------------------
module regfile_access_ctrl
    import regfile_access_ctrl_pkg::*;
#(
    parameter int               NREQ     = 2,
    parameter int               NREGS    = 8,
    parameter int               WIDTH    = 32,
    parameter int               IDXWIDTH = 3,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_access_ctrl_if.slave bus,
    output logic                init_done,
    output logic [IDXWIDTH-1:0] rf_i,
    output logic [WIDTH-1:0]    rf_d,
    output logic                rf_en,
    input  logic [WIDTH-1:0]    rf_q
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    rfc_state_e          state_q, state_d;
    logic [IDXWIDTH-1:0] init_cnt_q;
    logic [PW-1:0]       rr_ptr_q;
    logic [NREQ-1:0]     rsp_valid_q;
    logic [WIDTH-1:0]    rsp_rdata_q;
    logic                init_done_q;

    logic [NREQ-1:0]     arb_gnt;
    logic [PW-1:0]       arb_idx;
    logic                arb_any;

    logic [IDXWIDTH-1:0] sel_idx;
    logic                sel_write;
    logic [WIDTH-1:0]    sel_wdata;
    logic                in_range;
    logic                init_last;
    logic                run_acc;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .valid   (bus.req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    assign sel_idx   = bus.req_idx[arb_idx];
    assign sel_write = bus.req_write[arb_idx];
    assign sel_wdata = bus.req_wdata[arb_idx];
    // Only reachable false when NREGS is not a power of two.
    assign in_range  = int'(sel_idx) < NREGS;
    assign init_last = (init_cnt_q == IDXWIDTH'(NREGS - 1));
    assign run_acc   = (state_q == ST_RUN) && arb_any;

    always_comb begin
        state_d       = state_q;
        rf_en         = 1'b0;
        rf_i          = '0;
        rf_d          = '0;
        bus.req_ready = '0;
        case (state_q)
            ST_INIT: begin
                rf_en = 1'b1;
                rf_i  = init_cnt_q;
                rf_d  = INIT_VAL;
                if (init_last) state_d = ST_RUN;
            end
            ST_RUN: begin
                bus.req_ready = arb_gnt;
                if (arb_any) begin
                    rf_i = sel_idx;
                    // Out-of-range writes complete the handshake but never reach the array.
                    if (sel_write && in_range) begin
                        rf_en = 1'b1;
                        rf_d  = sel_wdata;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            rr_ptr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_done_q <= (state_d == ST_RUN);
            if (state_q == ST_INIT)
                init_cnt_q <= init_last ? '0 : init_cnt_q + 1'b1;
            rsp_valid_q <= run_acc ? arb_gnt : '0;
            if (run_acc) begin
                rr_ptr_q <= PW'(next_rr_ptr(int'(arb_idx), NREQ));
                if (!sel_write)
                    rsp_rdata_q <= in_range ? rf_q : '0;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign init_done     = init_done_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_access_ctrl
//  Directed bench: one controller with NREGS=8 and one with NREGS=6, each in
//  front of a behavioural register array preloaded with non-zero junk.
// ---------------------------------------------------------------------------
module tb_regfile_access_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_access_ctrl_if #(.NREQ(2), .IDXWIDTH(3), .WIDTH(32)) bus0 ();
    regfile_access_ctrl_if #(.NREQ(2), .IDXWIDTH(3), .WIDTH(32)) bus6 ();

    logic        init_done0, init_done6;
    logic [2:0]  rf_i0, rf_i6;
    logic [31:0] rf_d0, rf_d6, rf_q0, rf_q6;
    logic        rf_en0, rf_en6;

    regfile_access_ctrl #(.NREQ(2), .NREGS(8), .WIDTH(32), .IDXWIDTH(3), .INIT_VAL(32'h0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .init_done(init_done0),
        .rf_i(rf_i0), .rf_d(rf_d0), .rf_en(rf_en0), .rf_q(rf_q0)
    );

    regfile_access_ctrl #(.NREQ(2), .NREGS(6), .WIDTH(32), .IDXWIDTH(3), .INIT_VAL(32'h0)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .bus(bus6), .init_done(init_done6),
        .rf_i(rf_i6), .rf_d(rf_d6), .rf_en(rf_en6), .rf_q(rf_q6)
    );

    // Behavioural arrays: no reset, junk contents until the init walk.
    logic [31:0] mem0 [8] = '{32'hA5A50000, 32'hA5A50001, 32'hA5A50002, 32'hA5A50003,
                              32'hA5A50004, 32'hA5A50005, 32'hA5A50006, 32'hA5A50007};
    logic [31:0] mem6 [8] = '{32'hA5A50000, 32'hA5A50001, 32'hA5A50002, 32'hA5A50003,
                              32'hA5A50004, 32'hA5A50005, 32'hA5A50006, 32'hA5A50007};

    always @(posedge clk) begin
        if (rf_en0) mem0[rf_i0] <= rf_d0;
        if (rf_en6) mem6[rf_i6] <= rf_d6;
    end
    assign rf_q0 = mem0[rf_i0];
    assign rf_q6 = mem6[rf_i6];

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] exp_d [4] = '{32'hDEADBEEF, 32'h00001234, 32'hDEADBEEF, 32'h00001234};

    initial begin
        #50000;
        $display("FAIL watchdog: run did not finish, expected finish before 50000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus0.req_valid = 2'b11; bus0.req_write = '0; bus0.req_idx = '0; bus0.req_wdata = '0;
        bus6.req_valid = '0;    bus6.req_write = '0; bus6.req_idx = '0; bus6.req_wdata = '0;

        // Reset state, with requests already pending
        #12;
        chk("rst_rsp_valid", 32'(bus0.rsp_valid), 32'h0);
        chk("rst_rsp_rdata", bus0.rsp_rdata, 32'h0);
        chk("rst_init_done", 32'(init_done0), 32'h0);
        chk("rst_ready", 32'(bus0.req_ready), 32'h0);

        // 1: init walk over 8 entries
        #10 rst_n = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("init_en", 32'(rf_en0), 32'h1);
            chk("init_idx", 32'(rf_i0), 32'(i));
            chk("init_d", rf_d0, 32'h0);
            chk("init_ready", 32'(bus0.req_ready), 32'h0);
            chk("init_done_lo", 32'(init_done0), 32'h0);
            if (i == 7) bus0.req_valid = '0;
            tick();
        end
        chk("init_done_hi", 32'(init_done0), 32'h1);
        chk("idle_en", 32'(rf_en0), 32'h0);
        chk("init6_done", 32'(init_done6), 32'h1);

        // 2: req0 write idx3 then read idx3
        bus0.req_valid = 2'b01; bus0.req_write = 2'b01;
        bus0.req_idx[0] = 3'd3; bus0.req_wdata[0] = 32'hDEADBEEF;
        #1;
        chk("wr_ready", 32'(bus0.req_ready), 32'h1);
        chk("wr_en", 32'(rf_en0), 32'h1);
        chk("wr_idx", 32'(rf_i0), 32'h3);
        chk("wr_d", rf_d0, 32'hDEADBEEF);
        tick();
        chk("wr_ack", 32'(bus0.rsp_valid), 32'h1);
        bus0.req_write = 2'b00;
        #1;
        chk("rd_ready", 32'(bus0.req_ready), 32'h1);
        chk("rd_en", 32'(rf_en0), 32'h0);
        chk("rd_idx", 32'(rf_i0), 32'h3);
        tick();
        bus0.req_valid = '0;
        chk("rd_rsp", 32'(bus0.rsp_valid), 32'h1);
        chk("rd_data", bus0.rsp_rdata, 32'hDEADBEEF);
        tick();
        chk("rsp_pulse_end", 32'(bus0.rsp_valid), 32'h0);
        chk("rdata_hold", bus0.rsp_rdata, 32'hDEADBEEF);

        // Lone req1 write idx5 (pointer was 1 after two grants to 0, returns to 0)
        bus0.req_valid = 2'b10; bus0.req_write = 2'b10;
        bus0.req_idx[1] = 3'd5; bus0.req_wdata[1] = 32'h00001234;
        #1;
        chk("wr1_ready", 32'(bus0.req_ready), 32'h2);
        tick();
        bus0.req_valid = '0;
        chk("wr1_ack", 32'(bus0.rsp_valid), 32'h2);

        // 3: both requesters reading continuously -> alternating grants
        bus0.req_valid = 2'b11; bus0.req_write = 2'b00;
        bus0.req_idx[0] = 3'd3; bus0.req_idx[1] = 3'd5;
        #1;
        for (int c = 0; c < 4; c++) begin
            chk("rr_grant", 32'(bus0.req_ready), 32'(exp_g[c]));
            tick();
            if (c == 3) bus0.req_valid = '0;
            chk("rr_rsp", 32'(bus0.rsp_valid), 32'(exp_g[c]));
            chk("rr_data", bus0.rsp_rdata, exp_d[c]);
        end

        // 6: only req1 valid for 3 cycles, pointer ends back at 0
        bus0.req_valid = 2'b10;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("lone_grant", 32'(bus0.req_ready), 32'h2);
            tick();
            chk("lone_rsp", 32'(bus0.rsp_valid), 32'h2);
        end
        bus0.req_valid = 2'b11;
        #1;
        chk("ptr_back_0", 32'(bus0.req_ready), 32'h1);
        bus0.req_valid = '0;
        tick();

        // 4: NREGS=6, out-of-range idx7
        bus6.req_valid = 2'b01; bus6.req_write = 2'b01;
        bus6.req_idx[0] = 3'd7; bus6.req_wdata[0] = 32'h0000CAFE;
        #1;
        chk("oor_wr_ready", 32'(bus6.req_ready), 32'h1);
        chk("oor_wr_en", 32'(rf_en6), 32'h0);
        tick();
        chk("oor_wr_ack", 32'(bus6.rsp_valid), 32'h1);
        bus6.req_idx[0] = 3'd4; bus6.req_wdata[0] = 32'h00000077;
        #1;
        chk("ir_wr_en", 32'(rf_en6), 32'h1);
        chk("ir_wr_idx", 32'(rf_i6), 32'h4);
        tick();
        bus6.req_write = 2'b00;
        #1;
        tick();
        chk("ir_rd_data", bus6.rsp_rdata, 32'h00000077);
        bus6.req_idx[0] = 3'd7;
        #1;
        chk("oor_rd_ready", 32'(bus6.req_ready), 32'h1);
        tick();
        bus6.req_valid = '0;
        chk("oor_rd_rsp", 32'(bus6.rsp_valid), 32'h1);
        chk("oor_rd_data", bus6.rsp_rdata, 32'h0);
        chk("oor_wr_drop", mem6[7], 32'hA5A50007);

        // 5: write idx2, reset in the middle of a read, re-init clears the array
        bus0.req_valid = 2'b01; bus0.req_write = 2'b01;
        bus0.req_idx[0] = 3'd2; bus0.req_wdata[0] = 32'h00000055;
        tick();
        bus0.req_write = 2'b00;
        #1;
        chk("pre_rst_ready", 32'(bus0.req_ready), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp", 32'(bus0.rsp_valid), 32'h0);
        chk("mid_rst_rdata", bus0.rsp_rdata, 32'h0);
        chk("mid_rst_done", 32'(init_done0), 32'h0);
        chk("mid_rst_ready", 32'(bus0.req_ready), 32'h0);
        chk("mid_rst_en", 32'(rf_en0), 32'h1);
        tick();
        chk("lost_rsp", 32'(bus0.rsp_valid), 32'h0);
        bus0.req_valid = '0;
        #3 rst_n = 1'b1;
        repeat (8) tick();
        chk("reinit_done", 32'(init_done0), 32'h1);
        bus0.req_valid = 2'b01; bus0.req_write = 2'b01;
        bus0.req_idx[0] = 3'd1; bus0.req_wdata[0] = 32'h00000099;
        tick();
        bus0.req_write = 2'b00;
        #1;
        tick();
        chk("reinit_rd1_rsp", 32'(bus0.rsp_valid), 32'h1);
        chk("reinit_rd1", bus0.rsp_rdata, 32'h00000099);
        bus0.req_idx[0] = 3'd2;
        #1;
        tick();
        bus0.req_valid = '0;
        chk("reinit_rd2_rsp", 32'(bus0.rsp_valid), 32'h1);
        chk("reinit_rd2", bus0.rsp_rdata, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
